score4_move_driver: RTL and testbench
=====================================

SCORE4_MOVE_DRIVER -- requirements
Module: score4_move_driver

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 10, cycles each left/right/put pulse is held high.
REQ-002 SHALL have parameter NUM_COLS, default 7, number of board columns.
REQ-003 SHALL have parameter START_COL, default 0, cursor column after reset.
REQ-004 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  move request present.
REQ-007 SHALL have port req_col  input  3  target column for the token.
REQ-008 SHALL have port req_ready  output  1  driver can accept a request.
REQ-009 SHALL have port vsync  input  1  VGA vertical sync from the game (frame boundary = falling edge).
REQ-010 SHALL have port invalid_move, win_a, win_b, full_panel  input  1 each  game status.
REQ-011 SHALL have port left, right, put  output  1 each  button strobes into the game.
REQ-012 SHALL have port cur_col  output  3  tracked cursor column.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  completion status, valid only when done=1.

Function
REQ-015 SHALL implement states IDLE, STEP, STEP_WAIT, PUT, PUT_WAIT, FINISH.
REQ-016 SHALL assert req_ready only in IDLE while win_a, win_b and full_panel are all 0.
REQ-017 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, latching req_col.
REQ-018 On acceptance with latched col >= NUM_COLS SHALL go to FINISH with err=1 and no strobes.
REQ-019 On acceptance SHALL go to STEP if latched col != cur_col, else to PUT.
REQ-020 In STEP SHALL drive right=1 if target > cur_col, else left=1, for exactly PULSE_CYCLES cycles; never both.
REQ-021 At end of a STEP pulse SHALL increment/decrement cur_col by one and enter STEP_WAIT.
REQ-022 In STEP_WAIT SHALL hold all strobes 0 until the first vsync falling edge detected after entry, then re-enter STEP or enter PUT per REQ-019 comparison.
REQ-023 In PUT SHALL drive put=1 for exactly PULSE_CYCLES cycles, then enter PUT_WAIT.
REQ-024 In PUT_WAIT SHALL wait for the first vsync falling edge after entry, sample invalid_move on that edge cycle, then enter FINISH.
REQ-025 FINISH SHALL last one cycle with done=1, err = sampled invalid_move (or REQ-018/REQ-027 cause), then return to IDLE.
REQ-026 SHALL detect vsync falling edge from a registered copy of vsync (1-cycle detection latency); edges occurring while a pulse is active SHALL be ignored.
REQ-027 If win_a, win_b or full_panel is 1 on a STEP_WAIT or PUT_WAIT exit cycle, SHALL go to FINISH with err=1 without further strobes.
REQ-028 cur_col SHALL never leave 0..NUM_COLS-1; left SHALL never assert at cur_col=0, right never at NUM_COLS-1.
REQ-029 SHALL keep cur_col unchanged by put strobes.
REQ-030 req_valid while busy SHALL be ignored (no queueing).
REQ-031 Pulse counter width SHALL cover PULSE_CYCLES; no counter wrap within a pulse.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, left=right=put=0, done=0, err=0, cur_col=START_COL, pulse counter 0, vsync history 1.
REQ-033 rst asserted mid-pulse SHALL drop the active strobe asynchronously, abandoning the move with no done pulse.
REQ-034 After rst release req_ready SHALL be 1 on the first cycle if game status inputs are 0.

Verification
REQ-035 cur_col=0, request col 2 -> two right pulses of 10 cycles each separated by one frame edge, then 10-cycle put, done=1 err=0 one cycle after next frame edge, cur_col=2.
REQ-036 cur_col=2, request col 2 -> no left/right, single 10-cycle put, done=1 err=0.
REQ-037 Request col 7 -> no strobes, done=1 err=1 within 2 cycles of acceptance, cur_col unchanged.
REQ-038 Request put into full column with invalid_move=1 at frame edge -> done=1 err=1, cur_col unchanged.
REQ-039 win_a raised during STEP_WAIT of a 3-step move -> no further strobes, done=1 err=1, req_ready stays 0 while win_a=1.
REQ-040 rst pulsed during second right pulse -> right drops same cycle, cur_col=START_COL, no done.

Source files
------------

// File: rtl/score4_move_driver.sv
// Move driver for the Score-4 game: steps the cursor with left/right
// strobes, one column per frame, then drops a token with a put strobe.
module score4_move_driver #(
  parameter int PULSE_CYCLES = 10,
  parameter int NUM_COLS     = 7,
  parameter int START_COL    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_col,
  output logic       req_ready,
  input  logic       vsync,
  input  logic       invalid_move,
  input  logic       win_a,
  input  logic       win_b,
  input  logic       full_panel,
  output logic       left,
  output logic       right,
  output logic       put,
  output logic [2:0] cur_col,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [2:0] START = 3'(START_COL);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    STEP_WAIT,
    PUT,
    PUT_WAIT,
    FINISH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_target;
  logic [2:0]      r_cur_col;
  logic [CW-1:0]   r_cnt;
  logic            r_vs_q1;
  logic            r_vs_q2;
  logic            r_arm;
  logic            r_err;

  logic            w_over;
  logic            w_accept;
  logic            w_bad_col;
  logic            w_fall;
  logic            w_pulse_end;
  logic            w_go_right;
  logic            w_in_wait;

  assign w_over      = win_a | win_b | full_panel;
  assign req_ready   = (r_state == IDLE) && !w_over;
  assign w_accept    = req_valid & req_ready;
  assign w_bad_col   = int'(req_col) >= NUM_COLS;
  assign w_in_wait   = (r_state == STEP_WAIT) ||
                       (r_state == PUT_WAIT);
  // r_arm masks edges that were seen while a pulse was still active
  assign w_fall      = r_vs_q2 & ~r_vs_q1 & r_arm;
  assign w_pulse_end = (r_cnt == LAST);
  assign w_go_right  = r_target > r_cur_col;

  assign right   = (r_state == STEP) && w_go_right;
  assign left    = (r_state == STEP) && !w_go_right;
  assign put     = (r_state == PUT);
  assign cur_col = r_cur_col;
  assign done    = (r_state == FINISH);
  assign err     = done & r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad_col)
            w_next = FINISH;
          else if (req_col != r_cur_col)
            w_next = STEP;
          else
            w_next = PUT;
        end
      end
      STEP: begin
        if (w_pulse_end)
          w_next = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (w_fall) begin
          if (w_over)
            w_next = FINISH;
          else if (r_target != r_cur_col)
            w_next = STEP;
          else
            w_next = PUT;
        end
      end
      PUT: begin
        if (w_pulse_end)
          w_next = PUT_WAIT;
      end
      PUT_WAIT: begin
        if (w_fall)
          w_next = FINISH;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vs_q1 <= 1'b1;
      r_vs_q2 <= 1'b1;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vs_q1 <= vsync;
      r_vs_q2 <= r_vs_q1;
      r_arm   <= w_in_wait;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == STEP) || (r_state == PUT)) begin
      if (w_pulse_end)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_col <= START;
    end else if ((r_state == STEP) && w_pulse_end) begin
      if (w_go_right)
        r_cur_col <= r_cur_col + 3'd1;
      else
        r_cur_col <= r_cur_col - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_target <= req_col;
        r_err    <= w_bad_col;
      end
      if ((r_state == STEP_WAIT) && w_fall && w_over)
        r_err <= 1'b1;
      if ((r_state == PUT_WAIT) && w_fall)
        r_err <= invalid_move | w_over;
    end
  end

endmodule

// File: tb/tb_score4_move_driver.sv
// Bench for score4_move_driver: directed moves, expected results queued
// at issue time and checked by a monitor on each done pulse.
module tb_score4_move_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_col = 3'd0;
  logic       req_ready;
  logic       vsync = 1'b1;
  logic       invalid_move = 1'b0;
  logic       win_a = 1'b0;
  logic       win_b = 1'b0;
  logic       full_panel = 1'b0;
  logic       left, right, put;
  logic [2:0] cur_col;
  logic       done, err;

  typedef struct {
    logic       err;
    logic [2:0] col;
    int         nl;
    int         nr;
    int         np;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int acc_l = 0, acc_r = 0, acc_p = 0;

  score4_move_driver dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_col(req_col),
    .req_ready(req_ready), .vsync(vsync),
    .invalid_move(invalid_move), .win_a(win_a),
    .win_b(win_b), .full_panel(full_panel),
    .left(left), .right(right), .put(put),
    .cur_col(cur_col), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (30) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      vsync = 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: accumulates strobe cycles, compares on each done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_l = 0; acc_r = 0; acc_p = 0;
      end else begin
        if (left || right || put) begin
          checks++;
          if ((left && right) || (left && cur_col == 3'd0) ||
              (right && cur_col == 3'd6)) begin
            errors++;
            $display("FAIL strobe_rule: l=%0b r=%0b col=%0d",
                     left, right, cur_col);
          end
        end
        acc_l += int'(left);
        acc_r += int'(right);
        acc_p += int'(put);
        if (done) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            e = q.pop_front();
            chk("err", int'(err), int'(e.err));
            chk("cur_col", int'(cur_col), int'(e.col));
            chk("left_cycles", acc_l, e.nl);
            chk("right_cycles", acc_r, e.nr);
            chk("put_cycles", acc_p, e.np);
          end
          acc_l = 0; acc_r = 0; acc_p = 0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] col);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_col = col;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic expect_move(input logic e, input logic [2:0] c,
                             input int nl, input int nr, input int np);
    exp_t x;
    x.err = e; x.col = c; x.nl = nl; x.nr = nr; x.np = np;
    q.push_back(x);
  endtask

  task automatic wait_sig(input int which, input logic val);
    int n;
    n = 0;
    while (((which == 0) ? right : put) != val && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((which == 0) ? right : put) != val) begin
      errors++;
      $display("FAIL strobe_wait: got %0b expected %0b", !val, val);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_col", int'(cur_col), 0);
    chk("reset_strobes", int'({left, right, put, done}), 0);

    // 0 -> 2: two right pulses then put
    expect_move(1'b0, 3'd2, 0, 20, 10);
    issue(3'd2);
    drain();

    // same column: put only
    expect_move(1'b0, 3'd2, 0, 0, 10);
    issue(3'd2);
    drain();

    // out of range column
    expect_move(1'b1, 3'd2, 0, 0, 0);
    issue(3'd7);
    drain();

    // 2 -> 1 with one left pulse
    expect_move(1'b0, 3'd1, 10, 0, 10);
    issue(3'd1);
    drain();

    // put into full column
    invalid_move = 1'b1;
    expect_move(1'b1, 3'd1, 0, 0, 10);
    issue(3'd1);
    drain();
    invalid_move = 1'b0;

    // win during STEP_WAIT of 1 -> 4
    expect_move(1'b1, 3'd2, 0, 10, 0);
    issue(3'd4);
    wait_sig(0, 1'b1);
    wait_sig(0, 1'b0);
    win_a = 1'b1;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("ready_win", int'(req_ready), 0);
    end
    win_a = 1'b0;
    @(negedge clk);
    chk("ready_after_win", int'(req_ready), 1);

    // reset during second right pulse of 2 -> 5
    issue(3'd5);
    wait_sig(0, 1'b1);
    wait_sig(0, 1'b0);
    wait_sig(0, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_right", int'(right), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    repeat (100) @(negedge clk);

    // normal move after reset
    expect_move(1'b0, 3'd1, 0, 10, 10);
    issue(3'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
